// File: rtl/cdb_pkg.sv
// Shared types for the CDB result-collection stage: opcodes, result source
// encoding and the queued result entry.
package cdb_pkg;

  localparam int CDB_TAG_W  = 3;
  localparam int CDB_DATA_W = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_SD  = 4'b0010,
    OP_LD  = 4'b0011
  } op_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_DATA_W-1:0] instr;
  } cdb_entry_t;

  function automatic op_e instr_op(input logic [CDB_DATA_W-1:0] instr);
    return op_e'(instr[15:12]);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-producer result queue: synchronous FIFO with occupancy count,
// count-based ready and a synchronous flush of pointers and count.
module result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 35,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // ready depends only on the registered count: a full queue refuses even while popping
  assign push_ready = (count_q < CNT_W'(DEPTH));
  assign not_empty  = (count_q != {CNT_W{1'b0}});
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Next-state for pointers, count and storage
  always_comb begin
    push_ok  = push_valid && push_ready && !flush;
    pop_ok   = pop && not_empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects ALU and MEM results in private queues and broadcasts one per
// cycle on the registered common data bus, round-robin between the queues.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int TAG_W  = 3,
  parameter  int DATA_W = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] alu_instr,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_instr,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] cdb_instr,
  output logic              cdb_src,
  output logic [CNT_W-1:0]  alu_count,
  output logic [CNT_W-1:0]  mem_count
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t alu_push, mem_push;
  entry_t alu_head, mem_head;
  logic   alu_ne, mem_ne;
  logic   alu_pop, mem_pop;

  entry_t cdb_entry_q, cdb_entry_d;
  logic   cdb_valid_q, cdb_valid_d;
  src_e   cdb_src_q, cdb_src_d;
  src_e   last_grant_q, last_grant_d;

  assign alu_push = '{tag: alu_tag, data: alu_data, instr: alu_instr};
  assign mem_push = '{tag: mem_tag, data: mem_data, instr: mem_instr};

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .push_valid (alu_valid),
    .push_ready (alu_ready),
    .push_data  (alu_push),
    .pop        (alu_pop),
    .head       (alu_head),
    .count      (alu_count),
    .not_empty  (alu_ne)
  );

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mem_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .push_valid (mem_valid),
    .push_ready (mem_ready),
    .push_data  (mem_push),
    .pop        (mem_pop),
    .head       (mem_head),
    .count      (mem_count),
    .not_empty  (mem_ne)
  );

  // Round-robin grant; ALU wins a tie unless it was granted last. Idle cycles hold the payload.
  always_comb begin
    alu_pop      = 1'b0;
    mem_pop      = 1'b0;
    cdb_valid_d  = 1'b0;
    cdb_entry_d  = cdb_entry_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      last_grant_d = SRC_MEM;
    end else if (alu_ne && (!mem_ne || (last_grant_q == SRC_MEM))) begin
      alu_pop      = 1'b1;
      cdb_valid_d  = 1'b1;
      cdb_entry_d  = alu_head;
      cdb_src_d    = SRC_ALU;
      last_grant_d = SRC_ALU;
    end else if (mem_ne) begin
      mem_pop      = 1'b1;
      cdb_valid_d  = 1'b1;
      cdb_entry_d  = mem_head;
      cdb_src_d    = SRC_MEM;
      last_grant_d = SRC_MEM;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Broadcast register and last-grant pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid_q  <= 1'b0;
      cdb_entry_q  <= '0;
      cdb_src_q    <= SRC_ALU;
      last_grant_q <= SRC_MEM;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_entry_q  <= cdb_entry_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_entry_q.tag;
  assign cdb_data  = cdb_entry_q.data;
  assign cdb_instr = cdb_entry_q.instr;
  assign cdb_src   = cdb_src_q;

endmodule
